gcr_apple_prologue_detector: RTL and testbench

- Upstream stage for the encoding auto-detector. Frames the Apple II self-sync GCR byte stream from the DPLL bit stream, then matches the 3-byte prologue D5 AA xx.
- Its one-cycle `gcr_apple_sync` pulse drives the detector's `gcr_apple_sync` input.
- It also reports which prologue fired: DOS 3.3 address, data, or DOS 3.2 address. Upper layers use this to choose between the AP6 and AP5 encodings.

---
 rtl/gcr_apple_prologue_detector.sv | 82 ++++++++
 tb/tb_gcr_apple_prologue_detector.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/gcr_apple_prologue_detector.sv
// gcr_apple_prologue_detector: frames Apple II self-sync GCR bytes and flags D5 AA xx prologues.
module gcr_apple_prologue_detector #(
  parameter int         MAX_BYTE_BITS = 10,
  parameter logic [7:0] PRO3_ADDR6    = 8'h96,
  parameter logic [7:0] PRO3_DATA     = 8'hAD,
  parameter logic [7:0] PRO3_ADDR5    = 8'hB5
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       bit_in,
  input  logic       bit_valid,
  output logic [7:0] byte_out,
  output logic       byte_strobe,
  output logic       gcr_apple_sync,
  output logic [1:0] prologue_type,
  output logic [7:0] addr_count,
  output logic [7:0] data_count
);
  typedef enum logic [1:0] {IDLE, GOT_D5, GOT_AA} state_t;
  state_t state, state_nxt;
  logic [7:0] acc, next_acc;
  logic [3:0] bitcnt;
  logic [1:0] fire;
  logic done, timeout;
  assign next_acc = {acc[6:0], bit_in};
  assign done     = bit_valid && next_acc[7];
  assign timeout  = bit_valid && !next_acc[7] && bitcnt == 4'(MAX_BYTE_BITS - 1);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    fire = 2'b00;
    if (byte_strobe) begin
      case (state)
        IDLE:    state_nxt = byte_out == 8'hD5 ? GOT_D5 : IDLE;
        GOT_D5:  state_nxt = byte_out == 8'hAA ? GOT_AA : byte_out == 8'hD5 ? GOT_D5 : IDLE;
        GOT_AA: begin
          fire = byte_out == PRO3_ADDR6 ? 2'b01 : byte_out == PRO3_DATA ? 2'b10 :
                 byte_out == PRO3_ADDR5 ? 2'b11 : 2'b00;
          state_nxt = fire == 2'b00 && byte_out == 8'hD5 ? GOT_D5 : IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end else if (timeout && state != IDLE) state_nxt = IDLE;
    if (!enable) begin
      state_nxt = IDLE;
      fire = 2'b00;
    end
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      acc <= '0;
      bitcnt <= '0;
      byte_out <= '0;
      byte_strobe <= 1'b0;
      gcr_apple_sync <= 1'b0;
      prologue_type <= '0;
      addr_count <= '0;
      data_count <= '0;
    end else if (!enable) begin
      acc <= '0;
      bitcnt <= '0;
      byte_strobe <= 1'b0;
      gcr_apple_sync <= 1'b0;
    end else begin
      byte_strobe <= done;
      gcr_apple_sync <= fire != 2'b00;
      if (fire != 2'b00) prologue_type <= fire;
      if (fire[0] && addr_count != 8'hFF) addr_count <= addr_count + 8'd1;
      if (fire == 2'b10 && data_count != 8'hFF) data_count <= data_count + 8'd1;
      if (done) begin
        byte_out <= next_acc;
        acc <= '0;
        bitcnt <= '0;
      end else if (bit_valid) begin
        acc <= next_acc;
        bitcnt <= bitcnt == 4'hF ? bitcnt : bitcnt + 4'd1;
      end
    end
endmodule

// File: tb/tb_gcr_apple_prologue_detector.sv
// tb_gcr_apple_prologue_detector: directed-vector bench for the Apple GCR prologue detector.
module tb_gcr_apple_prologue_detector;
  logic clk = 0, reset_n = 0, enable = 0, bit_in = 0, bit_valid = 0;
  logic [7:0] byte_out, addr_count, data_count;
  logic byte_strobe, gcr_apple_sync, sync_prev = 0;
  logic [1:0] prologue_type;
  int tests = 0, fails = 0, sync_cnt = 0, wide_cnt = 0, s0;
  logic [7:0] strobe_log[$];
  logic [7:0] exp_bytes[7] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hD5, 8'hAA, 8'h96};

  gcr_apple_prologue_detector dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .bit_in(bit_in), .bit_valid(bit_valid),
    .byte_out(byte_out), .byte_strobe(byte_strobe), .gcr_apple_sync(gcr_apple_sync),
    .prologue_type(prologue_type), .addr_count(addr_count), .data_count(data_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (gcr_apple_sync) begin
      sync_cnt++;
      if (sync_prev) wide_cnt++;
    end
    sync_prev = gcr_apple_sync;
    if (byte_strobe) strobe_log.push_back(byte_out);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk);
    bit_in = b;
    bit_valid = 1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int zeros);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    repeat (zeros) send_bit(1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bit_valid = 0;
    end
  endtask

  task automatic prologue(input logic [7:0] b3);
    send_byte(8'hD5, 0);
    send_byte(8'hAA, 0);
    send_byte(b3, 0);
  endtask

  initial begin
    idle(3);
    chk("rst_byte_out", byte_out, 8'h00);
    chk("rst_strobe", byte_strobe, 0);
    chk("rst_sync", gcr_apple_sync, 0);
    chk("rst_type", prologue_type, 0);
    chk("rst_counts", {addr_count, data_count}, 0);
    reset_n = 1;
    enable = 1;
    idle(2);
    // 1: FF sync bytes then a DOS 3.3 address prologue, latency checked cycle by cycle
    strobe_log.delete();
    repeat (4) send_byte(8'hFF, 2);
    prologue(8'h96);
    idle(1);
    chk("t1_strobe", byte_strobe, 1);
    chk("t1_byte96", byte_out, 8'h96);
    chk("t1_sync_early", gcr_apple_sync, 0);
    idle(1);
    chk("t1_sync", gcr_apple_sync, 1);
    chk("t1_strobe_low", byte_strobe, 0);
    chk("t1_type", prologue_type, 2'b01);
    chk("t1_addr", addr_count, 1);
    idle(1);
    chk("t1_sync_off", gcr_apple_sync, 0);
    idle(2);
    chk("t1_nbytes", strobe_log.size(), 7);
    for (int i = 0; i < 7 && i < strobe_log.size(); i++) chk("t1_byte_seq", strobe_log[i], exp_bytes[i]);
    chk("t1_pulses", sync_cnt, 1);
    // 2: data then DOS 3.2 address
    s0 = sync_cnt;
    prologue(8'hAD);
    idle(3);
    chk("t2_type_data", prologue_type, 2'b10);
    chk("t2_data", data_count, 1);
    prologue(8'hB5);
    idle(3);
    chk("t2_type_a5", prologue_type, 2'b11);
    chk("t2_addr", addr_count, 2);
    chk("t2_pulses", sync_cnt - s0, 2);
    // 3: repeated D5, restarted prologue, bad third byte
    s0 = sync_cnt;
    send_byte(8'hD5, 0);
    prologue(8'hAD);
    idle(3);
    chk("t3_dd5", sync_cnt - s0, 1);
    chk("t3_data", data_count, 2);
    send_byte(8'hD5, 0);
    send_byte(8'hAA, 0);
    prologue(8'h96);
    idle(3);
    chk("t3_restart", sync_cnt - s0, 2);
    chk("t3_addr", addr_count, 3);
    prologue(8'h97);
    send_byte(8'hAA, 0);
    send_byte(8'h96, 0);
    idle(3);
    chk("t3_bad3", sync_cnt - s0, 2);
    chk("t3_type_hold", prologue_type, 2'b01);
    // 4: timeout after D5 vs accepted slip zeros
    s0 = sync_cnt;
    send_byte(8'hD5, 12);
    send_byte(8'hAA, 0);
    send_byte(8'h96, 0);
    idle(3);
    chk("t4_timeout12", sync_cnt - s0, 0);
    send_byte(8'hD5, 3);
    send_byte(8'hAA, 0);
    send_byte(8'h96, 0);
    idle(3);
    chk("t4_timeout3", sync_cnt - s0, 0);
    send_byte(8'hD5, 2);
    send_byte(8'hAA, 2);
    send_byte(8'h96, 0);
    idle(3);
    chk("t4_slip2", sync_cnt - s0, 1);
    chk("t4_addr", addr_count, 4);
    // 5: enable drop mid-prologue, then async reset mid-prologue
    s0 = sync_cnt;
    send_byte(8'hD5, 0);
    send_byte(8'hAA, 0);
    idle(3);
    @(negedge clk);
    enable = 0;
    @(negedge clk);
    chk("t5_byte_hold", byte_out, 8'hAA);
    enable = 1;
    send_byte(8'h96, 0);
    idle(3);
    chk("t5_en_nopulse", sync_cnt - s0, 0);
    chk("t5_en_counts", {addr_count, data_count}, {8'd4, 8'd2});
    chk("t5_en_byte", byte_out, 8'h96);
    send_byte(8'hD5, 0);
    send_byte(8'hAA, 0);
    idle(3);
    #2 reset_n = 0;
    #1;
    chk("t5_rst_outs", {byte_out, byte_strobe, gcr_apple_sync, prologue_type}, 0);
    chk("t5_rst_counts", {addr_count, data_count}, 0);
    #1 reset_n = 1;
    send_byte(8'h96, 0);
    idle(3);
    chk("t5_rst_nopulse", sync_cnt - s0, 0);
    // 6: counter saturation
    s0 = sync_cnt;
    repeat (300) prologue(8'h96);
    idle(3);
    chk("t6_pulses", sync_cnt - s0, 300);
    chk("t6_addr_sat", addr_count, 8'hFF);
    chk("t6_data", data_count, 0);
    chk("t6_width", wide_cnt, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
